dma_mem_arbiter: RTL

Three-master arbiter between the core's data/instruction memory buses, a new DMA master, and the shared multiplexed memory bus (q_m_*). That bus feeds the SDRAM, BIOS and VGA decode. It replaces the two-master arbitration path and lets a DMA engine (floppy/SD transfers) reach system memory without CPU involvement. It holds one transaction in flight at a time, uses registered grant and address, and has bounded DMA starvation of the CPU.

---
 rtl/dma_mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dma_mem_arbiter.sv
// Three-master arbiter (DMA, CPU data, CPU instruction) onto the shared q_m_* memory bus.
// One transaction in flight; grant and bus fields are registered, acks are steered
// combinationally from q_m_ack while BUSY. DMA has priority but is capped at
// DMA_MAX_BURST consecutive grants while the CPU is waiting.
module dma_mem_arbiter #(
    parameter int unsigned DMA_MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_in_n,
    input  logic [18:0] data_m_addr,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    input  logic [18:0] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic [18:0] dma_m_addr,
    input  logic [15:0] dma_m_data_out,
    input  logic        dma_m_access,
    input  logic        dma_m_wr_en,
    input  logic [1:0]  dma_m_bytesel,
    output logic        dma_m_ack,
    output logic [15:0] dma_m_data_in,
    output logic [18:0] q_m_addr,
    output logic [15:0] q_m_data_out,
    output logic        q_m_access,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    input  logic        q_m_ack,
    input  logic [15:0] q_m_data_in
);

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;
    typedef enum logic [1:0] {G_NONE, G_DATA, G_INSTR, G_DMA} grant_e;

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    logic [CW-1:0] dma_cnt_q, dma_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          acc_q, acc_d;
    logic          wr_q, wr_d;
    logic [BW-1:0] bs_q, bs_d;

    logic          cpu_pend;
    logic          dma_win;
    logic          ack_fire;

    assign cpu_pend = data_m_access | instr_m_access;
    // DMA wins unless it has used up its burst allowance while the CPU waits
    assign dma_win  = dma_m_access & ~((dma_cnt_q == CW'(DMA_MAX_BURST)) & cpu_pend);

    // Next-state, grant selection and bus field capture
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        dma_cnt_d = dma_cnt_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        acc_d     = acc_q;
        wr_d      = wr_q;
        bs_d      = bs_q;
        case (state_q)
            S_IDLE: begin
                if (dma_m_access | cpu_pend) begin
                    state_d = S_BUSY;
                    acc_d   = 1'b1;
                    if (dma_win) begin
                        grant_d = G_DMA;
                        addr_d  = dma_m_addr;
                        dout_d  = dma_m_data_out;
                        wr_d    = dma_m_wr_en;
                        bs_d    = dma_m_bytesel;
                        if (!cpu_pend) begin
                            dma_cnt_d = '0;
                        end else if (dma_cnt_q != CW'(DMA_MAX_BURST)) begin
                            dma_cnt_d = dma_cnt_q + CW'(1);
                        end
                    end else if (data_m_access) begin
                        grant_d   = G_DATA;
                        addr_d    = data_m_addr;
                        dout_d    = data_m_data_out;
                        wr_d      = data_m_wr_en;
                        bs_d      = data_m_bytesel;
                        dma_cnt_d = '0;
                    end else begin
                        grant_d   = G_INSTR;
                        addr_d    = instr_m_addr;
                        dout_d    = '0;
                        wr_d      = 1'b0;
                        bs_d      = 2'b11;
                        dma_cnt_d = '0;
                    end
                end
            end
            S_BUSY: begin
                if (q_m_ack) begin
                    acc_d   = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
                acc_d   = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= S_IDLE;
            grant_q   <= G_NONE;
            dma_cnt_q <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            acc_q     <= 1'b0;
            wr_q      <= 1'b0;
            bs_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            dma_cnt_q <= dma_cnt_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            acc_q     <= acc_d;
            wr_q      <= wr_d;
            bs_q      <= bs_d;
        end
    end

    assign q_m_addr     = addr_q;
    assign q_m_data_out = dout_q;
    assign q_m_access   = acc_q;
    assign q_m_wr_en    = wr_q;
    assign q_m_bytesel  = bs_q;

    // Completion is only honoured while a transaction is on the bus
    assign ack_fire        = (state_q == S_BUSY) & q_m_ack;
    assign data_m_ack      = ack_fire & (grant_q == G_DATA);
    assign instr_m_ack     = ack_fire & (grant_q == G_INSTR);
    assign dma_m_ack       = ack_fire & (grant_q == G_DMA);
    assign data_m_data_in  = data_m_ack  ? q_m_data_in : '0;
    assign instr_m_data_in = instr_m_ack ? q_m_data_in : '0;
    assign dma_m_data_in   = dma_m_ack   ? q_m_data_in : '0;

endmodule
